// File: rtl/mem_resp_pkg.sv
// Shared bus constants for the byte memory responder: bus/address widths,
// default IO byte address, write-strobe encoding and the IO status byte layout.
package mem_resp_pkg;
  localparam int               BUS_W       = 8;
  localparam int               ADDR_W      = 32;
  localparam logic [ADDR_W-1:0] IO_ADDR_DEF = 32'h0003_0000;
  localparam logic             WR_WRITE    = 1'b1;

  function automatic logic [BUS_W-1:0] status_byte(input logic ovf, input logic full);
    return {6'b0, ovf, full};
  endfunction
endpackage

// File: rtl/mem_resp_if.sv
// CPU byte bus plus IO drain signals; master = core/consumer side, slave = responder.
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic [ADDR_W-1:0] rom_a;
  logic              rom_wr;
  logic [BUS_W-1:0]  rom_wn;
  logic [BUS_W-1:0]  rom_rn;
  logic [BUS_W-1:0]  io_data;
  logic              io_valid;
  logic              io_ready;
  logic              io_full;
  logic              io_ovf;

  modport master (
    output rom_a, rom_wr, rom_wn, io_ready,
    input  rom_rn, io_data, io_valid, io_full, io_ovf
  );

  modport slave (
    input  rom_a, rom_wr, rom_wn, io_ready,
    output rom_rn, io_data, io_valid, io_full, io_ovf
  );
endinterface

// File: rtl/mem_resp_io_fifo.sv
// Small synchronous byte FIFO feeding the IO drain; drops pushes when full
// (unless a pop frees the slot in the same cycle) and records a sticky overflow.
module mem_resp_io_fifo
  import mem_resp_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [BUS_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [BUS_W-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             ovf_o
);
  localparam int DEPTH = 2**FIFO_AW;

  logic [BUS_W-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic               empty, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      if (push_i && !do_push) ovf_q <= 1'b1;
    end
  end

  assign valid_o = !empty;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/mem_resp.sv
// Byte memory responder: local RAM with a fixed RD_LAT-cycle read pipeline.
// Define MEM_RESP_IO_EN to map IO_ADDR onto an output byte FIFO with status readback.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int                AW      = 17,
  parameter int                RD_LAT  = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR = IO_ADDR_DEF,
  parameter int                FIFO_AW = 3
) (
  input logic       clk,
  input logic       rst,
  mem_resp_if.slave bus
);
  logic [BUS_W-1:0] ram_q [2**AW];
  logic [BUS_W-1:0] pipe_q [RD_LAT];
  logic [AW-1:0]    idx;
  logic             is_wr, io_hit, ram_we;
  logic [BUS_W-1:0] status, rd_byte;

  assign idx    = bus.rom_a[AW-1:0];
  assign is_wr  = (bus.rom_wr == WR_WRITE);
  assign ram_we = is_wr && !io_hit;

`ifdef MEM_RESP_IO_EN
  logic fifo_full, fifo_ovf;

  assign io_hit = (bus.rom_a == IO_ADDR);

  mem_resp_io_fifo #(.FIFO_AW(FIFO_AW)) u_io_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (is_wr && io_hit),
    .push_data_i (bus.rom_wn),
    .pop_i       (bus.io_ready),
    .head_o      (bus.io_data),
    .valid_o     (bus.io_valid),
    .full_o      (fifo_full),
    .ovf_o       (fifo_ovf)
  );

  assign bus.io_full = fifo_full;
  assign bus.io_ovf  = fifo_ovf;
  assign status      = status_byte(fifo_ovf, fifo_full);
`else
  logic unused_io;

  assign unused_io    = ^{bus.io_ready, bus.rom_a[ADDR_W-1:AW], IO_ADDR, FIFO_AW[0]};
  assign io_hit       = 1'b0;
  assign status       = '0;
  assign bus.io_data  = '0;
  assign bus.io_valid = 1'b0;
  assign bus.io_full  = 1'b0;
  assign bus.io_ovf   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx] <= bus.rom_wn;
  end

  // Writes occupy their pipeline slot with zero so the read cadence never bubbles.
  assign rd_byte = is_wr ? '0 : (io_hit ? status : ram_q[idx]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rd_byte;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bus.rom_rn = pipe_q[RD_LAT-1];
endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench: three responders (RD_LAT 1/2/4) share one stimulus stream;
// expected read bytes are queued per request and popped as each pipeline delivers.
module tb_mem_resp;
  import mem_resp_pkg::*;

  localparam int          AW   = 17;
  localparam logic [31:0] IO_A = 32'h0003_0000;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = 32'h10;
  logic        wr  = 1'b0;
  logic [7:0]  wn  = 8'h00;
  logic        rdy = 1'b0;

  always #5 clk = ~clk;

  mem_resp_if b1 ();
  mem_resp_if b2 ();
  mem_resp_if b4 ();

  assign b1.rom_a = a;  assign b1.rom_wr = wr;  assign b1.rom_wn = wn;  assign b1.io_ready = rdy;
  assign b2.rom_a = a;  assign b2.rom_wr = wr;  assign b2.rom_wn = wn;  assign b2.io_ready = rdy;
  assign b4.rom_a = a;  assign b4.rom_wr = wr;  assign b4.rom_wn = wn;  assign b4.io_ready = rdy;

  mem_resp #(.AW(AW), .RD_LAT(1), .IO_ADDR(IO_A), .FIFO_AW(3)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_resp #(.AW(AW), .RD_LAT(2), .IO_ADDR(IO_A), .FIFO_AW(3)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  mem_resp #(.AW(AW), .RD_LAT(4), .IO_ADDR(IO_A), .FIFO_AW(3)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  exp_t       q1[$], q2[$], q4[$];
  logic [7:0] ram_m [int];
  logic [7:0] fifo_m[$];
  logic       ovf_m = 1'b0;
  logic [10:0] exp_io;   // {valid, full, ovf, data} after the previous edge
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       mon_e;

  // One bus request per call; model state advances as the coming edge will.
  task automatic tick(input logic w, input logic [31:0] addr, input logic [7:0] d, input logic r);
    exp_t e;
    int   key;
    logic hit, pop;
    @(negedge clk);
    wr = w; a = addr; wn = d; rdy = r;
    key = int'(addr[AW-1:0]);
`ifdef MEM_RESP_IO_EN
    hit = (addr == IO_A);
`else
    hit = 1'b0;
`endif
    exp_io = {fifo_m.size() > 0, fifo_m.size() == 8, ovf_m,
              (fifo_m.size() > 0) ? fifo_m[0] : 8'h00};
    if (w)                    e = '{1'b1, 8'h00};
    else if (hit)             e = '{1'b1, {6'b0, ovf_m, fifo_m.size() == 8}};
    else if (ram_m.exists(key)) e = '{1'b1, ram_m[key]};
    else                      e = '{1'b0, 8'h00};
    if (rst) begin
      q1.push_back(e); q2.push_back(e); q4.push_back(e);
      if (w && !hit) ram_m[key] = d;
      pop = r && (fifo_m.size() > 0);
      if (pop) void'(fifo_m.pop_front());
      if (w && hit) begin
        if (fifo_m.size() < 8) fifo_m.push_back(d);
        else ovf_m = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (q1.size() >= 1) begin
        mon_e = q1.pop_front();
        if (mon_e.chk) begin
          vectors++;
          if (b1.rom_rn !== mon_e.val) begin
            miscompares++;
            $display("FAIL rd_lat1 t=%0t rom_rn=%h expected=%h", $time, b1.rom_rn, mon_e.val);
          end
        end
      end
      if (q2.size() >= 2) begin
        mon_e = q2.pop_front();
        if (mon_e.chk) begin
          vectors++;
          if (b2.rom_rn !== mon_e.val) begin
            miscompares++;
            $display("FAIL rd_lat2 t=%0t rom_rn=%h expected=%h", $time, b2.rom_rn, mon_e.val);
          end
        end
      end
      if (q4.size() >= 4) begin
        mon_e = q4.pop_front();
        if (mon_e.chk) begin
          vectors++;
          if (b4.rom_rn !== mon_e.val) begin
            miscompares++;
            $display("FAIL rd_lat4 t=%0t rom_rn=%h expected=%h", $time, b4.rom_rn, mon_e.val);
          end
        end
      end
    end
  end

  task automatic test_reset;
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({b1.rom_rn, b2.rom_rn, b4.rom_rn} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_rom_rn got=%h/%h/%h expected=00", b1.rom_rn, b2.rom_rn, b4.rom_rn);
    end
    vectors++;
    if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_io got=%b%b%b_%h expected=000_00", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data);
    end
    @(posedge clk); #2 rst = 1'b1;
  endtask

  task automatic test_raw_latency;
    tick(1'b1, 32'h10, 8'hA5, 1'b0);
    tick(1'b0, 32'h10, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h10, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [4] = '{8'h13, 8'h05, 8'h00, 8'h93};
    for (int i = 0; i < 4; i++) tick(1'b1, 32'(i), pat[i], 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'(i), 8'h00, 1'b0);
    tick(1'b1, 32'h0002_0010, 8'h7E, 1'b0);
    tick(1'b0, 32'h0000_0010, 8'h00, 1'b0);
    tick(1'b0, 32'h0002_0010, 8'h00, 1'b0);
    tick(1'b1, 32'h0001_0000, 8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h3, 8'h00, 1'b0);
  endtask

  task automatic test_io;
    tick(1'b1, IO_A, 8'h48, 1'b0);
    tick(1'b1, IO_A, 8'h69, 1'b0);
    tick(1'b0, 32'h10, 8'h00, 1'b1);
    vectors++;
    if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
      miscompares++;
      $display("FAIL io_first got=%b%b%b_%h expected=%h", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
    end
`ifdef MEM_RESP_IO_EN
    vectors++;
    if (b1.io_data !== 8'h48) begin
      miscompares++;
      $display("FAIL io_H got=%h expected=48", b1.io_data);
    end
`endif
    tick(1'b0, 32'h10, 8'h00, 1'b1);
    vectors++;
    if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
      miscompares++;
      $display("FAIL io_second got=%b%b%b_%h expected=%h", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
    end
    tick(1'b0, 32'h0001_0000, 8'h00, 1'b0);
    vectors++;
    if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
      miscompares++;
      $display("FAIL io_drained got=%b%b%b_%h expected=%h", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h10, 8'h00, 1'b0);
  endtask

  task automatic test_push_pop_full;
    for (int i = 0; i < 8; i++) tick(1'b1, IO_A, 8'h80 + 8'(i), 1'b0);
    tick(1'b1, IO_A, 8'hC9, 1'b1);
    tick(1'b0, 32'h10, 8'h00, 1'b0);
    vectors++;
    if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
      miscompares++;
      $display("FAIL pushpop_full got=%b%b%b_%h expected=%h", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
    end
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 32'h10, 8'h00, 1'b1);
      vectors++;
      if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
        miscompares++;
        $display("FAIL drain_%0d got=%b%b%b_%h expected=%h", i, b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
      end
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, IO_A, 8'h30 + 8'(i), 1'b0);
      if (i == 8) begin
        vectors++;
        if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
          miscompares++;
          $display("FAIL ovf_after8 got=%b%b%b_%h expected=%h", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
        end
      end
    end
    tick(1'b0, IO_A, 8'h00, 1'b0);
    vectors++;
    if ({b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data} !== exp_io) begin
      miscompares++;
      $display("FAIL ovf_after9 got=%b%b%b_%h expected=%h", b1.io_valid, b1.io_full, b1.io_ovf, b1.io_data, exp_io);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h10, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    tick(1'b1, 32'h20, 8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 32'h20, 8'h00, 1'b0);
    #2 rst = 1'b0;
    q1.delete(); q2.delete(); q4.delete(); fifo_m.delete(); ovf_m = 1'b0;
    #1;
    vectors++;
    if ({b1.rom_rn, b2.rom_rn, b4.rom_rn} !== 24'h0) begin
      miscompares++;
      $display("FAIL midreset_rom_rn got=%h/%h/%h expected=00", b1.rom_rn, b2.rom_rn, b4.rom_rn);
    end
    vectors++;
    if ({b1.io_valid, b1.io_ovf, b1.io_full} !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_io got=%b%b%b expected=000", b1.io_valid, b1.io_ovf, b1.io_full);
    end
    @(posedge clk); #2 rst = 1'b1;
    tick(1'b0, 32'h20, 8'h00, 1'b0);
    tick(1'b0, 32'h10, 8'h00, 1'b0);
    tick(1'b0, IO_A, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_raw_latency();
    test_back_to_back();
    test_io();
    test_push_pop_full();
    test_overflow();
    test_reset_mid();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
